// File: rtl/cb_pkg.sv
// Shared definitions for the CB address skew generator: defaults, FSM encoding
// and the lane-slice helper used to address the flat per-lane buses.
package cb_pkg;
  localparam int CB_AW_DEF = 19;
  localparam int L_DEF     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic int lane_lsb(input int lane, input int aw);
    return lane * aw;
  endfunction
endpackage

// File: rtl/cb_lane_skew.sv
// L-stage register chain carrying {en, addr}; dir picks the entry lane and
// the shift direction, so each lane is a registered copy of its upstream neighbour.
module cb_lane_skew
  import cb_pkg::*;
#(
  parameter int L  = L_DEF,
  parameter int AW = CB_AW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            dir,
  input  logic            in_en,
  input  logic [AW-1:0]   in_addr,
  output logic [L-1:0]    lane_en,
  output logic [AW*L-1:0] lane_addr
);

  logic          en_q   [L];
  logic [AW-1:0] addr_q [L];

  for (genvar i = 0; i < L; i++) begin : g_lane
    localparam int UP = (i == 0) ? 0 : i - 1;
    localparam int DN = (i == L - 1) ? L - 1 : i + 1;

    logic          nxt_en;
    logic [AW-1:0] nxt_addr;

    always_comb begin
      if (!dir) begin
        nxt_en   = (i == 0) ? in_en   : en_q[UP];
        nxt_addr = (i == 0) ? in_addr : addr_q[UP];
      end else begin
        nxt_en   = (i == L - 1) ? in_en   : en_q[DN];
        nxt_addr = (i == L - 1) ? in_addr : addr_q[DN];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        en_q[i]   <= 1'b0;
        addr_q[i] <= '0;
      end else begin
        en_q[i]   <= nxt_en;
        addr_q[i] <= nxt_addr;
      end
    end

    assign lane_en[i]                      = en_q[i];
    assign lane_addr[lane_lsb(i, AW) +: AW] = addr_q[i];
  end

endmodule

// File: rtl/cb_addr_skew_gen.sv
// Strided CB BRAM address burst generator: one start command produces a burst
// that is skewed one cycle per lane across L lanes, with optional bank offset.
module cb_addr_skew_gen
  import cb_pkg::*;
#(
  parameter int L       = L_DEF,
  parameter int CB_AW   = CB_AW_DEF,
  parameter int ROW_LEN = 10,
  parameter int BURST_W = 4
) (
  input  logic               clk,
  input  logic               sys_rst,
  input  logic               start,
  input  logic [CB_AW-1:0]   base_addr,
  input  logic [CB_AW-1:0]   stride,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               dir,
  input  logic               lane_ofs_en,
  input  logic [ROW_LEN-1:0] group_cnt,
  output logic               busy,
  output logic               done,
  output logic [L-1:0]       CB_en,
  output logic [CB_AW*L-1:0] CB_addr
);

  localparam int DW = $clog2(L);

  state_t             state;
  logic [CB_AW-1:0]   acc;
  logic [CB_AW-1:0]   stride_q;
  logic [BURST_W-1:0] len_q;
  logic [BURST_W-1:0] cnt;
  logic [DW-1:0]      dcnt;
  logic               dir_q;
  logic               ofs_q;
  logic               odd_q;

  logic               accept;
  logic               last;
  logic               inj_en;
  logic [CB_AW-1:0]   inj_addr;
  logic               chain_dir;
  logic [L-1:0]       lane_en;
  logic [CB_AW*L-1:0] lane_addr;
  logic               unused_grp;

  assign unused_grp = ^group_cnt[ROW_LEN-1:1];

  assign accept    = (state == IDLE) && start && (burst_len != '0);
  assign last      = (cnt == len_q - 1'b1);
  assign chain_dir = (state == IDLE) ? dir : dir_q;

  // Element 0 enters the chain straight from the command so it shows on the
  // entry lane one cycle after start; RUN then feeds elements 1..len-1.
  always_comb begin
    inj_en   = 1'b0;
    inj_addr = '0;
    if (accept) begin
      inj_en   = 1'b1;
      inj_addr = base_addr;
    end else if (state == RUN && !last) begin
      inj_en   = 1'b1;
      inj_addr = acc;
    end
  end

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      acc      <= '0;
      stride_q <= '0;
      len_q    <= '0;
      cnt      <= '0;
      dcnt     <= '0;
      dir_q    <= 1'b0;
      ofs_q    <= 1'b0;
      odd_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= RUN;
            busy     <= 1'b1;
            acc      <= base_addr + stride;
            stride_q <= stride;
            len_q    <= burst_len;
            cnt      <= '0;
            dir_q    <= dir;
            ofs_q    <= lane_ofs_en;
            odd_q    <= group_cnt[0];
          end
        end
        RUN: begin
          if (last) begin
            state <= DRAIN;
            dcnt  <= DW'(1);
            done  <= (L == 2);
          end else begin
            cnt <= cnt + 1'b1;
            acc <= acc + stride_q;
          end
        end
        DRAIN: begin
          if (dcnt == DW'(L - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end else begin
            dcnt <= dcnt + 1'b1;
            done <= (dcnt + 1'b1 == DW'(L - 1));
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  cb_lane_skew #(
    .L  (L),
    .AW (CB_AW)
  ) u_skew (
    .clk       (clk),
    .rst_n     (sys_rst),
    .dir       (chain_dir),
    .in_en     (inj_en),
    .in_addr   (inj_addr),
    .lane_en   (lane_en),
    .lane_addr (lane_addr)
  );

  // Bank offset is added only here; odd groups mirror the lane order.
  for (genvar i = 0; i < L; i++) begin : g_out
    logic [CB_AW-1:0] ofs;

    always_comb begin
      ofs = '0;
      if (ofs_q) ofs = odd_q ? CB_AW'(L - 1 - i) : CB_AW'(i);
    end

    assign CB_en[i] = lane_en[i];
    assign CB_addr[lane_lsb(i, CB_AW) +: CB_AW] =
      lane_en[i] ? lane_addr[lane_lsb(i, CB_AW) +: CB_AW] + ofs : '0;
  end

endmodule

// File: tb/tb_cb_addr_skew_gen.sv
// Bench for cb_addr_skew_gen: directed scenarios plus random commands, all
// checked every cycle against a per-cycle schedule built from the burst rules.
module tb_cb_addr_skew_gen;
  localparam int L    = 4;
  localparam int AW   = 19;
  localparam int RL   = 10;
  localparam int BW   = 4;
  localparam int MAXC = 4096;

  logic            clk = 1'b0;
  logic            sys_rst = 1'b0;
  logic            start = 1'b0;
  logic [AW-1:0]   base_addr = '0;
  logic [AW-1:0]   stride = '0;
  logic [BW-1:0]   burst_len = '0;
  logic            dir = 1'b0;
  logic            lane_ofs_en = 1'b0;
  logic [RL-1:0]   group_cnt = '0;
  logic            busy;
  logic            done;
  logic [L-1:0]    CB_en;
  logic [AW*L-1:0] CB_addr;

  cb_addr_skew_gen #(.L(L), .CB_AW(AW), .ROW_LEN(RL), .BURST_W(BW)) dut (
    .clk         (clk),
    .sys_rst     (sys_rst),
    .start       (start),
    .base_addr   (base_addr),
    .stride      (stride),
    .burst_len   (burst_len),
    .dir         (dir),
    .lane_ofs_en (lane_ofs_en),
    .group_cnt   (group_cnt),
    .busy        (busy),
    .done        (done),
    .CB_en       (CB_en),
    .CB_addr     (CB_addr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_done = -1;
  bit chk_on = 1'b0;

  bit            exp_en   [MAXC][L];
  logic [AW-1:0] exp_addr [MAXC][L];
  bit            exp_busy [MAXC];
  bit            exp_done [MAXC];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [L-1:0]    e;
    logic [AW*L-1:0] a;
    if (chk_on) begin
      for (int i = 0; i < L; i++) begin
        e[i]          = exp_en[cyc][i];
        a[i*AW +: AW] = exp_addr[cyc][i];
      end
      chk("CB_en", CB_en, e);
      chk("CB_addr", CB_addr, a);
      chk("busy", busy, exp_busy[cyc]);
      chk("done", done, exp_done[cyc]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) tick();
  endtask

  // Present a command for one cycle and, if the generator should take it,
  // schedule every element on every lane at its arrival cycle.
  task automatic issue(input int b, input int s, input int len, input bit d,
                       input bit o, input int g);
    int lane, c, ofs;
    base_addr   = AW'(b);
    stride      = AW'(s);
    burst_len   = BW'(len);
    dir         = d;
    lane_ofs_en = o;
    group_cnt   = RL'(g);
    start       = 1'b1;
    if (len != 0 && cyc > last_done) begin
      for (int k = 0; k < len; k++) begin
        for (int dd = 0; dd < L; dd++) begin
          lane = d ? (L - 1 - dd) : dd;
          c    = cyc + 1 + k + dd;
          ofs  = o ? ((g % 2 == 1) ? (L - 1 - lane) : lane) : 0;
          exp_en[c][lane]   = 1'b1;
          exp_addr[c][lane] = AW'(longint'(b) + longint'(k) * longint'(s) + longint'(ofs));
        end
      end
      for (int c2 = cyc + 1; c2 <= cyc + len + L - 1; c2++) exp_busy[c2] = 1'b1;
      exp_done[cyc + len + L - 1] = 1'b1;
      last_done = cyc + len + L - 1;
    end
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    sys_rst = 1'b0;
    #1;
    chk("rst_en", CB_en, '0);
    chk("rst_addr", CB_addr, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    for (int c = cyc; c < MAXC; c++) begin
      for (int i = 0; i < L; i++) begin
        exp_en[c][i]   = 1'b0;
        exp_addr[c][i] = '0;
      end
      exp_busy[c] = 1'b0;
      exp_done[c] = 1'b0;
    end
    last_done = -1;
    tick();
    tick();
    sys_rst = 1'b1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  initial begin
    for (int c = 0; c < MAXC; c++) begin
      for (int i = 0; i < L; i++) begin
        exp_en[c][i]   = 1'b0;
        exp_addr[c][i] = '0;
      end
      exp_busy[c] = 1'b0;
      exp_done[c] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("por_en", CB_en, '0);
    chk("por_addr", CB_addr, '0);
    chk("por_busy", busy, 1'b0);
    chk("por_done", done, 1'b0);
    sys_rst = 1'b1;
    cyc     = 0;
    chk_on  = 1'b1;
    idle(2);

    // Reset while idle, then while a burst is in flight.
    do_reset();
    idle(1);
    issue(1000, 3, 8, 1'b0, 1'b1, 1);
    idle(3);
    do_reset();
    idle(3);
    issue(5, 1, 1, 1'b0, 1'b0, 0);
    idle(6);

    // Plain burst in both directions.
    issue(100, 1, 3, 1'b0, 1'b0, 0);
    idle(8);
    issue(100, 1, 3, 1'b1, 1'b0, 0);
    idle(8);

    // Address wrap with bank offset, even then odd group.
    issue(524280, 8, 2, 1'b0, 1'b1, 0);
    idle(7);
    issue(524280, 8, 2, 1'b0, 1'b1, 1);
    idle(7);

    // Ignored commands: start while busy, zero-length start while idle.
    issue(200, 2, 5, 1'b0, 1'b0, 0);
    idle(1);
    issue(700, 7, 4, 1'b1, 1'b1, 0);
    wait_until(last_done + 2);
    issue(300, 1, 0, 1'b0, 1'b0, 0);
    idle(3);

    // Start in the done cycle is dropped; start right after it is taken.
    issue(40, 4, 3, 1'b1, 1'b0, 0);
    wait_until(last_done);
    issue(900, 9, 2, 1'b0, 1'b1, 1);
    issue(60, 5, 4, 1'b0, 1'b1, 0);
    wait_until(last_done + 1);
    issue(80, 2, 15, 1'b1, 1'b1, 1);
    wait_until(last_done + 3);

    // Random back-to-back and done-cycle starts.
    repeat (40) begin
      issue($urandom_range(0, (1 << AW) - 1), $urandom_range(0, (1 << AW) - 1),
            $urandom_range(1, 15), 1'($urandom), 1'($urandom), $urandom_range(0, 1023));
      wait_until(last_done + $urandom_range(0, 1));
    end

    // Random free-running traffic, including zero lengths and busy starts.
    repeat (600) begin
      if ($urandom_range(0, 3) == 0)
        issue($urandom_range(0, (1 << AW) - 1), $urandom_range(0, (1 << AW) - 1),
              $urandom_range(0, 15), 1'($urandom), 1'($urandom), $urandom_range(0, 1023));
      else
        idle(1);
    end
    idle(L + 18);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
